// File: rtl/shk_ctrl_if.sv
// shk control handshake bundle between the GPIO mapping stage (master) and the executor (slave).
interface shk_ctrl_if #(
  parameter int WD_SYNC = 16,
  parameter int WD_DLAY = 15
) ();
  // 4-phase level handshake: master raises wvalid with smosi/dmosi stable, slave raises
  // wready with smiso/dmiso valid, master drops wvalid, slave drops wready; a wvalid drop
  // before wready rises cancels the request.
  logic               wvalid;
  logic [WD_SYNC-1:0] smosi;
  logic [WD_DLAY-1:0] dmosi;
  logic               wready;
  logic [WD_SYNC-1:0] smiso;
  logic [WD_DLAY-1:0] dmiso;

  modport master (output wvalid, smosi, dmosi, input wready, smiso, dmiso);
  modport slave  (input wvalid, smosi, dmosi, output wready, smiso, dmiso);
endinterface

// File: rtl/shk_ctrl_exec.sv
// shk control executor: delayed one-cycle trigger, waits for datapath done, answers with code and cycle count.
// Optional SHK_CTRL_SYNC_EN: 2-flop synchronizer on wvalid ahead of edge detect and abort logic.
module shk_ctrl_exec #(
  parameter int WD_SYNC = 16,
  parameter int WD_DLAY = 15
) (
  input  logic               s_sys_base_clock,
  input  logic               s_sys_base_reset,
  shk_ctrl_if.slave          s_shk_ctrl,
  output logic               m_trig_pulse,
  output logic [WD_SYNC-1:0] m_trig_code,
  input  logic               m_trig_done,
  output logic               m_busy,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DLAY = 3'd1,
    TRIG = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t             state;
  logic               wv;
  logic               wvalid_d;
  logic               armed;
  logic               rise;
  logic [WD_DLAY-1:0] cnt;
  logic [WD_DLAY-1:0] elapsed;
  logic               wready_q;
  logic [WD_SYNC-1:0] smiso_q;
  logic [WD_DLAY-1:0] dmiso_q;

`ifdef SHK_CTRL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge s_sys_base_clock) begin
    if (s_sys_base_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], s_shk_ctrl.wvalid};
    end
  end

  assign wv = sync_q[1];
`else
  assign wv = s_shk_ctrl.wvalid;
`endif

  // armed blocks a wvalid that is already high when reset releases from counting as a rise.
  assign rise = wv & ~wvalid_d & armed;

  always_ff @(posedge s_sys_base_clock) begin
    if (s_sys_base_reset) begin
      state        <= IDLE;
      wvalid_d     <= 1'b0;
      armed        <= 1'b0;
      cnt          <= '0;
      elapsed      <= '0;
      m_trig_pulse <= 1'b0;
      m_trig_code  <= '0;
      m_busy       <= 1'b0;
      wready_q     <= 1'b0;
      smiso_q      <= '0;
      dmiso_q      <= '0;
    end else begin
      wvalid_d     <= wv;
      m_trig_pulse <= 1'b0;
      if (!s_shk_ctrl.wvalid) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (rise) begin
            m_trig_code <= s_shk_ctrl.smosi;
            cnt         <= s_shk_ctrl.dmosi;
            m_busy      <= 1'b1;
            if (s_shk_ctrl.dmosi == '0) begin
              state        <= TRIG;
              m_trig_pulse <= 1'b1;
            end else begin
              state <= DLAY;
            end
          end
        end
        DLAY: begin
          if (!wv) begin
            state  <= IDLE;
            m_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == WD_DLAY'(1)) begin
              state        <= TRIG;
              m_trig_pulse <= 1'b1;
            end
          end
        end
        TRIG: begin
          elapsed <= '0;
          if (!wv) begin
            state  <= IDLE;
            m_busy <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A falling wvalid wins over a coincident done.
          if (!wv) begin
            state  <= IDLE;
            m_busy <= 1'b0;
          end else if (m_trig_done) begin
            smiso_q  <= m_trig_code;
            dmiso_q  <= elapsed;
            wready_q <= 1'b1;
            state    <= RESP;
          end else if (elapsed != '1) begin
            elapsed <= elapsed + 1'b1;
          end
        end
        RESP: begin
          if (!wv) begin
            wready_q <= 1'b0;
            state    <= IDLE;
            m_busy   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          m_busy   <= 1'b0;
          wready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_shk_ctrl.wready = wready_q;
  assign s_shk_ctrl.smiso  = smiso_q;
  assign s_shk_ctrl.dmiso  = dmiso_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_shk_ctrl_exec.sv
// Directed bench for shk_ctrl_exec: timeline model of each request checked every cycle, plus literal spot checks.
module tb_shk_ctrl_exec;
  localparam int WS   = 16;
  localparam int WDL  = 15;
  localparam int W    = WS + WDL;
  localparam int HUGE = 1 << 28;
  localparam int DMAX = (1 << WDL) - 1;
  localparam int NONE = -100;
`ifdef SHK_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  shk_ctrl_if #(.WD_SYNC(WS), .WD_DLAY(WDL)) sif ();
  logic          trig_pulse, trig_done, busy;
  logic [WS-1:0] trig_code;
  logic [2:0]    dbg;

  shk_ctrl_exec #(.WD_SYNC(WS), .WD_DLAY(WDL)) dut (
    .s_sys_base_clock (clk),
    .s_sys_base_reset (rst),
    .s_shk_ctrl       (sif.slave),
    .m_trig_pulse     (trig_pulse),
    .m_trig_code      (trig_code),
    .m_trig_done      (trig_done),
    .m_busy           (busy),
    .dbg_state        (dbg)
  );

  shk_ctrl_if #(.WD_SYNC(WS), .WD_DLAY(4)) sif4 ();
  logic          trig_pulse4, trig_done4, busy4;
  logic [WS-1:0] trig_code4;
  logic [2:0]    dbg4;

  shk_ctrl_exec #(.WD_SYNC(WS), .WD_DLAY(4)) dut4 (
    .s_sys_base_clock (clk),
    .s_sys_base_reset (rst),
    .s_shk_ctrl       (sif4.slave),
    .m_trig_pulse     (trig_pulse4),
    .m_trig_code      (trig_code4),
    .m_trig_done      (trig_done4),
    .m_busy           (busy4),
    .dbg_state        (dbg4)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int fail_prints = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (fail_prints < 25) begin
        fail_prints++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- request timeline model ----------------
  // Edge numbers: value of cyc right after that posedge. The current request is described by
  // the edge where wvalid is first seen high (t_re), first seen low (t_fe), reset (t_rx), and
  // the edge at which done is accepted (t_d).
  int            w_on = 0, w_off = 10, d_on = HUGE, d_off = HUGE;
  int            rst_init_end = 4, rst_edge = HUGE;
  int            t_r = HUGE, t_re = HUGE, t_fe = HUGE, t_rx = HUGE, t_pe = HUGE, t_d = HUGE;
  logic          t_pulse_ok = 1'b0, t_has_d = 1'b0;
  logic [WS-1:0] t_code = '0;
  int            t_dm = 0;
  logic [WS-1:0] prev_code = '0, prev_smiso = '0;
  int            prev_dmiso = 0;
  int            pulse_cnt = 0, last_pulse = -1, wready_cycles = 0;
  logic          wready_prev = 1'b0;

  always @(negedge clk) begin
    int e;
    e = cyc + 1;
    sif.wvalid = (e >= w_on) && (e < w_off);
    trig_done  = (e >= d_on) && (e < d_off);
    rst        = (e <= rst_init_end) || (e == rst_edge);
  end

  task automatic compare_cycle(input int n);
    logic          e_pulse, e_busy, e_wready;
    logic [WS-1:0] e_code, e_smiso;
    int            e_dmiso;
    logic [W-1:0]  exp_v;
    if (n >= t_rx) begin
      e_pulse = 1'b0; e_busy = 1'b0; e_wready = 1'b0;
      e_code = '0; e_smiso = '0; e_dmiso = 0;
    end else begin
      e_busy   = (n >= t_re) && (n < t_fe);
      e_pulse  = t_pulse_ok && (n == t_pe);
      e_wready = t_has_d && (n >= t_d) && (n < t_fe);
      e_code   = (n >= t_re) ? t_code : prev_code;
      if (t_has_d && n >= t_d) begin
        e_smiso = t_code; e_dmiso = t_dm;
      end else begin
        e_smiso = prev_smiso; e_dmiso = prev_dmiso;
      end
    end
    if (trig_pulse) begin
      pulse_cnt++;
      last_pulse = n;
    end
    if (sif.wready) wready_cycles++;
    check("pulse", trig_pulse, e_pulse);
    check("busy", busy, e_busy);
    check("dbg_busy", (dbg != 3'd0), e_busy);
    check("wready", sif.wready, e_wready);
    check("trig_code", trig_code, e_code);
    check("smiso", sif.smiso, e_smiso);
    check("dmiso", sif.dmiso, e_dmiso);
    if (sif.wready && !wready_prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        check("sb_resp", {sif.smiso, sif.dmiso}, exp_v);
      end
    end
    wready_prev = sif.wready;
  endtask

  always @(posedge clk) begin
    #1;
    compare_cycle(cyc);
  end

  // ---------------- driver ----------------
  // done_rel counts edges from the first WAIT edge (negative lands in TRIG); done_len < 0 holds done.
  task automatic run_txn(input logic [WS-1:0] code, input int dly, input int hold,
                         input int done_rel, input int done_len, input int rst_rel, input int gap);
    int r, f, w0, ds, de;
    @(posedge clk);
    #2;
    if (t_rx != HUGE) begin
      prev_code = '0; prev_smiso = '0; prev_dmiso = 0;
    end else begin
      if (t_re != HUGE) prev_code = t_code;
      if (t_has_d) begin
        prev_smiso = t_code;
        prev_dmiso = t_dm;
      end
    end
    r    = cyc + 2;
    t_r  = r;
    t_re = r + LAT;
    t_pe = t_re + dly;
    w0   = t_pe + 2;
    if (rst_rel >= 0) begin
      t_rx = t_re + rst_rel;
      f    = t_rx;
    end else begin
      t_rx = HUGE;
      f    = r + hold;
    end
    t_fe = f + LAT;
    ds   = (done_rel == NONE) ? HUGE : w0 + done_rel;
    de   = (done_len < 0) ? HUGE : ds + done_len;
    t_code     = code;
    t_pulse_ok = (t_fe > t_pe) && (t_rx > t_pe);
    t_d        = (ds > w0) ? ds : w0;
    t_has_d    = t_pulse_ok && (t_fe > t_pe + 1) && (t_d < de) && (t_d < t_fe) && (t_d < t_rx);
    t_dm       = (t_d - w0 > DMAX) ? DMAX : t_d - w0;
    if (t_has_d) exp_q.push_back({code, t_dm[WDL-1:0]});
    sif.smosi     = code;
    sif.dmosi     = dly[WDL-1:0];
    pulse_cnt     = 0;
    wready_cycles = 0;
    last_pulse    = -1;
    w_on     = r;
    w_off    = f;
    d_on     = ds;
    d_off    = de;
    rst_edge = (t_rx == HUGE) ? HUGE : t_rx;
    while (cyc < t_fe + gap) @(posedge clk);
    #2;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    sif.smosi    = 16'hFFFF;
    sif.dmosi    = '0;
    sif4.wvalid  = 1'b0;
    sif4.smosi   = '0;
    sif4.dmosi   = '0;
    trig_done4   = 1'b0;

    // wvalid already high across reset release must not start a request
    while (cyc < 14) @(posedge clk);
    #2;
    check("oor_busy", busy, 0);
    check("oor_pulses", pulse_cnt, 0);
    check("oor_wready", sif.wready, 0);

    // D = 0, done after three quiet WAIT cycles
    run_txn(16'h00A5, 0, 12, 3, 1, -1, 4);
    check("a_pulse_ofs", last_pulse - t_r, LAT);
    check("a_pulses", pulse_cnt, 1);
    check("a_smiso", sif.smiso, 16'h00A5);
    check("a_dmiso", sif.dmiso, 3);

    // D = 10, done in the first WAIT cycle
    run_txn(16'h0B0B, 10, 30, 0, 1, -1, 4);
    check("b_pulse_ofs", last_pulse - t_r, 10 + LAT);
    check("b_dmiso", sif.dmiso, 0);

    // long wready hold: response from re+5 until fall at re+60
    run_txn(16'h5A5A, 2, 60, 1, 1, -1, 3);
    check("c_wready_len", wready_cycles, 55);
    check("c_dmiso", sif.dmiso, 1);
    check("c_busy_after", busy, 0);
    check("c_wready_after", sif.wready, 0);

    // second-code request, done already high during TRIG
    run_txn(16'h1234, 1, 20, -1, 3, -1, 3);
    check("d_smiso", sif.smiso, 16'h1234);
    check("d_dmiso", sif.dmiso, 0);

    // abort in DLAY
    run_txn(16'hDEAD, 100, 20, NONE, 0, -1, 10);
    check("e_pulses", pulse_cnt, 0);
    check("e_wready_cycles", wready_cycles, 0);
    check("e_smiso", sif.smiso, 16'h1234);
    check("e_dmiso", sif.dmiso, 0);

    // abort in WAIT coincident with done, done then held high
    run_txn(16'hC0DE, 3, 9, 4, -1, -1, 20);
    check("f_pulses", pulse_cnt, 1);
    check("f_wready_cycles", wready_cycles, 0);
    check("f_smiso", sif.smiso, 16'h1234);

    // abort sampled in TRIG keeps the pulse
    run_txn(16'h0F0F, 0, 1, NONE, 0, -1, 5);
    check("g_pulses", pulse_cnt, 1);
    check("g_trig_code", trig_code, 16'h0F0F);

    // maximum delay
    run_txn(16'h7FFF, DMAX, DMAX + 8, 2, 1, -1, 3);
    check("h_pulse_ofs", last_pulse - t_r, DMAX + LAT);
    check("h_dmiso", sif.dmiso, 2);

    // reset while in WAIT
    run_txn(16'h7777, 2, 0, NONE, 0, 7, 5);
    check("i_busy", busy, 0);
    check("i_wready", sif.wready, 0);
    check("i_smiso", sif.smiso, 0);
    check("i_dmiso", sif.dmiso, 0);
    check("i_trig_code", trig_code, 0);

    // recovery after reset
    run_txn(16'h0042, 0, 10, 2, 1, -1, 4);
    check("j_smiso", sif.smiso, 16'h0042);
    check("j_dmiso", sif.dmiso, 2);

    // elapsed saturation on the 4-bit instance
    @(negedge clk);
    sif4.smosi  = 16'h0BEE;
    sif4.dmosi  = 4'd0;
    sif4.wvalid = 1'b1;
    repeat (44) @(negedge clk);
    trig_done4 = 1'b1;
    k = 0;
    while (!sif4.wready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("sat_wready", sif4.wready, 1);
    check("sat_dmiso", sif4.dmiso, 15);
    check("sat_smiso", sif4.smiso, 16'h0BEE);
    sif4.wvalid = 1'b0;
    trig_done4  = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("sat_wready_low", sif4.wready, 0);
    check("sat_busy_low", busy4, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shk_ctrl_exec.md
Name: shk_ctrl_exec

Overview:
- Slave/executor for the shk control handshake driven from PS GPIO; sits directly downstream of the GPIO-to-shk mapping stage.
- Captures a sync code (smosi) and a delay count (dmosi) on a wvalid rising edge, waits the delay, then fires a one-cycle trigger toward the light-eye datapath.
- Waits for the datapath's done, then answers with wready, echoing the code (smiso) and the measured cycle count (dmiso).
- Handshake is 4-phase level-based, since software toggles GPIO bits.

Parameters:
- WD_SYNC, 16, width of sync code (smosi/smiso/m_trig_code)
- WD_DLAY, 15, width of delay count and elapsed count (dmosi/dmiso)

Ports:
- s_sys_base_clock  input  1  system clock, all logic on rising edge
- s_sys_base_reset  input  1  synchronous active-high reset
- s_shk_ctrl_wvalid  input  1  request level from software
- s_shk_ctrl_smosi  input  WD_SYNC  sync code, stable while wvalid high
- s_shk_ctrl_dmosi  input  WD_DLAY  pre-trigger delay in clocks
- s_shk_ctrl_wready  output  1  response level
- s_shk_ctrl_smiso  output  WD_SYNC  echoed code of last completed request
- s_shk_ctrl_dmiso  output  WD_DLAY  trigger-to-done cycles of last completed request
- m_trig_pulse  output  1  one-cycle trigger
- m_trig_code  output  WD_SYNC  code of current request, valid from TRIG until next capture
- m_trig_done  input  1  datapath completion, level or pulse
- m_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, internal wvalid_d 0, counters 0. Reset mid-operation aborts silently: no pulse, no wready.
- Edge detect: rise = wvalid & ~wvalid_d; wvalid_d registered every cycle.
- IDLE:
  - On rise at edge k: latch code <= smosi, m_trig_code <= smosi, cnt <= dmosi.
  - Next state is TRIG if dmosi == 0, else DLAY.
  - wvalid already high out of reset is not a rise.
- DLAY:
  - cnt decrements each cycle; when cnt == 1, next state is TRIG.
  - Net timing: m_trig_pulse is high in the cycle after edge k+D, for any D >= 0.
  - D = all-ones is legal (2^WD_DLAY-1 cycles).
- TRIG:
  - m_trig_pulse = 1 for exactly one cycle; elapsed <= 0; next state WAIT.
  - m_trig_done during TRIG is ignored.
- WAIT:
  - If m_trig_done: smiso <= code, dmiso <= elapsed, next state RESP.
  - Else elapsed increments, saturating at all-ones.
  - Done in the first WAIT cycle gives dmiso = 0.
- RESP:
  - wready = 1 (registered), held while wvalid = 1.
  - When wvalid == 0: next state IDLE, wready deasserts on the same edge.
- Abort: wvalid == 0 sampled in DLAY, TRIG or WAIT returns to IDLE.
  - Abort from DLAY suppresses the pulse; abort sampled in TRIG does not cancel a pulse already registered.
  - smiso/dmiso keep their previous values; wready stays 0.
  - Abort has priority over m_trig_done in the same cycle.
- Retrigger: a new rise is accepted only in IDLE. Rises are impossible in other states because wvalid must fall first, and any fall aborts or completes.
- smiso/dmiso update only on entry to RESP and hold otherwise.

Optional Feature:
- SHK_CTRL_SYNC_EN defined:
  - wvalid passes through a 2-flop synchronizer (reset 0) before edge detect and abort logic.
  - smosi/dmosi are captured at the synchronized rise.
  - All latencies relative to raw wvalid grow by 2 cycles.
- Not defined: wvalid is used directly; it is the same clock domain as the GPIO.

Test Plan:
- smosi = 0x00A5, dmosi = 0, wvalid rises at edge k:
  - m_trig_pulse high in the cycle after edge k, m_trig_code = 0x00A5.
  - Done 3 cycles after pulse gives dmiso = 3 (pulse cycle excluded: done in first WAIT cycle gives 0), smiso = 0x00A5, wready = 1.
- dmosi = 10: pulse exactly 10 cycles later than the D = 0 case.
- Full handshake:
  - wready stays 1 while wvalid is held 50 cycles.
  - wvalid low gives wready 0 next edge, m_busy 0.
  - A second request with code 0x1234 works.
- Abort in DLAY (dmosi = 100, wvalid drops after 20 cycles): no pulse, wready never asserts, smiso/dmiso unchanged.
- Abort in WAIT with m_trig_done coincident: returns IDLE, no wready; m_trig_done held high indefinitely, pulse never repeats.
- Saturation and reset:
  - WD_DLAY = 4, done never arrives for 40 cycles, then done: dmiso = 15.
  - Reset asserted in WAIT: all outputs 0 next cycle.
  - With SHK_CTRL_SYNC_EN, the D = 0 pulse is 2 cycles later.
